// File: rtl/mesi_pkg.sv
// Shared types for the MESI snooping-bus controller: per-cache line states,
// bus FSM states and the snoop-side state transition.
package mesi_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_state_t;

  typedef enum logic [2:0] {
    BUS_IDLE,
    BUS_SNOOP,
    BUS_EVICT,
    BUS_FILL,
    BUS_RESP
  } bus_state_t;

  // A peer holding the snooped line drops to S on a read and to I on a write.
  function automatic mesi_state_t snoop_next(input mesi_state_t cur, input logic is_write);
    if (cur == MESI_I || is_write) return MESI_I;
    return MESI_S;
  endfunction

endpackage

// File: rtl/mesi_rr_arbiter.sv
// N-way round-robin arbiter: grants the first request at or after the pointer,
// and moves the pointer past the grantee when the advance strobe is high.
module mesi_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_cand;
  logic          w_found;

  // NOTE: every variable written in this block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = IW'((int'(r_ptr) + k) % N);
      if (!w_found && i_req[w_cand]) begin
        w_found        = 1'b1;
        o_gnt[w_cand]  = 1'b1;
        o_gnt_idx      = w_cand;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_gnt_idx == IW'(N - 1)) ? '0 : o_gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/mesi_bus_ctrl.sv
// Snooping-bus MESI controller for N single-line caches: arbitrates requests,
// snoops peers, and drives line state, tags and one-cycle memory strobes.
module mesi_bus_ctrl
  import mesi_pkg::*;
#(
  parameter int N  = 2,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr [N],
  input  logic [N-1:0]  read_req,
  input  logic [N-1:0]  write_req,
  output logic [N-1:0]  done,
  output logic [N-1:0]  mem_read,
  output logic [N-1:0]  mem_write,
  output logic [1:0]    state [N],
  output logic [AW-1:0] line_addr [N]
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  bus_state_t    r_bus, w_bus_nxt;
  mesi_state_t   r_state [N];
  mesi_state_t   w_state_nxt [N];
  logic [AW-1:0] r_line [N];
  logic [AW-1:0] w_line_nxt [N];
  logic [IW-1:0] r_g;
  logic          r_write;
  logic [AW-1:0] r_addr;
  logic          r_shared, w_shared_nxt;
  logic [N-1:0]  r_done, r_mem_read, r_mem_write;
  logic [N-1:0]  w_done_nxt, w_mem_read_nxt, w_mem_write_nxt;
  logic [N-1:0]  w_req, w_gnt;
  logic [IW-1:0] w_gnt_idx;
  logic          w_advance;
  logic          w_g_hit;

  assign w_req     = read_req | write_req;
  assign w_advance = (r_bus == BUS_IDLE) && (|w_req);

  mesi_rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_req),
    .i_advance (w_advance),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_g_hit = (r_line[r_g] == r_addr) && (r_state[r_g] != MESI_I);

  // Strobe registers are loaded with the value belonging to the state being entered,
  // which keeps every output a one-cycle registered Moore pulse.
  always_comb begin
    w_bus_nxt       = r_bus;
    w_shared_nxt    = r_shared;
    w_done_nxt      = '0;
    w_mem_read_nxt  = '0;
    w_mem_write_nxt = '0;
    for (int j = 0; j < N; j++) begin
      w_state_nxt[j] = r_state[j];
      w_line_nxt[j]  = r_line[j];
    end
    unique case (r_bus)
      BUS_IDLE: begin
        if (w_advance) begin
          w_bus_nxt = BUS_SNOOP;
          for (int j = 0; j < N; j++) begin
            if (j != int'(w_gnt_idx) && r_line[j] == addr[w_gnt_idx] && r_state[j] == MESI_M)
              w_mem_write_nxt[j] = 1'b1;
          end
        end
      end
      BUS_SNOOP: begin
        w_shared_nxt = 1'b0;
        for (int j = 0; j < N; j++) begin
          if (j != int'(r_g) && r_line[j] == r_addr && r_state[j] != MESI_I) begin
            w_shared_nxt   = 1'b1;
            w_state_nxt[j] = snoop_next(r_state[j], r_write);
          end
        end
        if (w_g_hit) begin
          if (r_write) w_state_nxt[r_g] = MESI_M;
          w_bus_nxt       = BUS_RESP;
          w_done_nxt[r_g] = 1'b1;
        end else if (r_state[r_g] == MESI_M) begin
          w_bus_nxt            = BUS_EVICT;
          w_mem_write_nxt[r_g] = 1'b1;
        end else begin
          w_bus_nxt           = BUS_FILL;
          w_mem_read_nxt[r_g] = 1'b1;
        end
      end
      BUS_EVICT: begin
        w_state_nxt[r_g]    = MESI_I;
        w_bus_nxt           = BUS_FILL;
        w_mem_read_nxt[r_g] = 1'b1;
      end
      BUS_FILL: begin
        w_line_nxt[r_g]  = r_addr;
        w_state_nxt[r_g] = r_write ? MESI_M : (r_shared ? MESI_S : MESI_E);
        w_bus_nxt        = BUS_RESP;
        w_done_nxt[r_g]  = 1'b1;
      end
      BUS_RESP: w_bus_nxt = BUS_IDLE;
      default:  w_bus_nxt = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus       <= BUS_IDLE;
      r_g         <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_shared    <= 1'b0;
      r_done      <= '0;
      r_mem_read  <= '0;
      r_mem_write <= '0;
      // NOTE: the per-cache line registers are reset too, since "invalid, tag 0" must be visible straight after reset.
      for (int j = 0; j < N; j++) begin
        r_state[j] <= MESI_I;
        r_line[j]  <= '0;
      end
    end else begin
      r_bus       <= w_bus_nxt;
      r_shared    <= w_shared_nxt;
      r_done      <= w_done_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      for (int j = 0; j < N; j++) begin
        r_state[j] <= w_state_nxt[j];
        r_line[j]  <= w_line_nxt[j];
      end
      if (w_advance) begin
        r_g     <= w_gnt_idx;
        r_write <= |(write_req & w_gnt);
        r_addr  <= addr[w_gnt_idx];
      end
    end
  end

  assign done      = r_done;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;

  always_comb begin
    for (int j = 0; j < N; j++) begin
      state[j]     = r_state[j];
      line_addr[j] = r_line[j];
    end
  end

endmodule

// File: tb/tb_mesi_bus_ctrl.sv
// Directed bench for mesi_bus_ctrl (N=2): per-cycle strobe traces and final
// line states are compared with hand-computed values.
module tb_mesi_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr [2];
  logic [1:0]  read_req, write_req;
  logic [1:0]  done, mem_read, mem_write;
  logic [1:0]  state [2];
  logic [31:0] line_addr [2];

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] tr_done, tr_mr, tr_mw;
  logic [1:0]  snap_state0;
  logic [31:0] snap_line0;

  always #5 clk = ~clk;

  mesi_bus_ctrl #(.N(2), .AW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .read_req  (read_req),
    .write_req (write_req),
    .done      (done),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .state     (state),
    .line_addr (line_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Trace word with mask m placed at cycle Tk (two bits per cycle, T1 in bits [1:0]).
  function automatic logic [15:0] at(input int k, input logic [1:0] m);
    logic [15:0] r;
    r = '0;
    r[2*(k-1) +: 2] = m;
    return r;
  endfunction

  // Records T1..Tncyc at negedges; requesters drop on their done; optional reset at rst_at.
  task automatic observe(input int ncyc, input int rst_at);
    tr_done = '0;
    tr_mr   = '0;
    tr_mw   = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      tr_done[2*(k-1) +: 2] = done;
      tr_mr[2*(k-1) +: 2]   = mem_read;
      tr_mw[2*(k-1) +: 2]   = mem_write;
      read_req  = read_req & ~done;
      write_req = write_req & ~done;
      if (k == rst_at) begin
        snap_state0 = state[0];
        snap_line0  = line_addr[0];
        rst       = 1'b1;
        read_req  = '0;
        write_req = '0;
      end
    end
  endtask

  task automatic run_req(input int idx, input bit wr, input logic [31:0] a);
    @(negedge clk);
    addr[idx] = a;
    if (wr) write_req[idx] = 1'b1;
    else    read_req[idx]  = 1'b1;
    observe(8, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    read_req  = '0;
    write_req = '0;
    addr[0]   = '0;
    addr[1]   = '0;
    repeat (3) @(negedge clk);
    check("rst state0", state[0], 0);
    check("rst state1", state[1], 0);
    check("rst line0", line_addr[0], 0);
    check("rst strobes", {done, mem_read, mem_write}, 0);
    rst = 1'b0;

    // Cold read by cache0.
    run_req(0, 1'b0, 32'h100);
    check("cold rd done", tr_done, at(3, 2'b01));
    check("cold rd mr", tr_mr, at(2, 2'b01));
    check("cold rd mw", tr_mw, 0);
    check("cold rd st0", state[0], 2);
    check("cold rd st1", state[1], 0);
    check("cold rd tag0", line_addr[0], 32'h100);

    // Cache1 reads the same line: E peer drops to S, no writeback.
    run_req(1, 1'b0, 32'h100);
    check("shr rd done", tr_done, at(3, 2'b10));
    check("shr rd mr", tr_mr, at(2, 2'b10));
    check("shr rd mw", tr_mw, 0);
    check("shr rd st0", state[0], 1);
    check("shr rd st1", state[1], 1);

    // Cache0 write hit from S: upgrade to M, peer invalidated.
    run_req(0, 1'b1, 32'h100);
    check("wr hit done", tr_done, at(2, 2'b01));
    check("wr hit mem", {tr_mr, tr_mw}, 0);
    check("wr hit st0", state[0], 3);
    check("wr hit st1", state[1], 0);

    // Cache1 read: M peer writes back in T1, both end in S.
    run_req(1, 1'b0, 32'h100);
    check("snp wb mw", tr_mw, at(1, 2'b01));
    check("snp wb mr", tr_mr, at(2, 2'b10));
    check("snp wb done", tr_done, at(3, 2'b10));
    check("snp wb st0", state[0], 1);
    check("snp wb st1", state[1], 1);

    // Re-dirty cache0, then a conflicting read forces an eviction.
    run_req(0, 1'b1, 32'h100);
    check("redirty done", tr_done, at(2, 2'b01));
    check("redirty st0", state[0], 3);
    run_req(0, 1'b0, 32'h200);
    check("evict mw", tr_mw, at(2, 2'b01));
    check("evict mr", tr_mr, at(3, 2'b01));
    check("evict done", tr_done, at(4, 2'b01));
    check("evict st0", state[0], 2);
    check("evict tag0", line_addr[0], 32'h200);
    check("evict st1", state[1], 0);

    // Pointer back to 0, then simultaneous requests; reset lands in cache1's FILL.
    do_reset();
    @(negedge clk);
    addr[0]      = 32'h300;
    addr[1]      = 32'h400;
    read_req[0]  = 1'b1;
    write_req[1] = 1'b1;
    observe(6, 6);
    check("sim done", tr_done, at(3, 2'b01));
    check("sim mr", tr_mr, at(2, 2'b01) | at(6, 2'b10));
    check("sim mw", tr_mw, 0);
    check("sim st0", snap_state0, 2);
    check("sim tag0", snap_line0, 32'h300);
    @(negedge clk);
    check("mid rst strobes", {done, mem_read, mem_write}, 0);
    check("mid rst st", {state[0], state[1]}, 0);
    check("mid rst tags", line_addr[0] | line_addr[1], 0);
    rst = 1'b0;
    observe(4, 0);
    check("no late done", tr_done, 0);

    // After reset the pointer is 0 again: cache0 first, cache1 shares the line.
    @(negedge clk);
    addr[0]     = 32'h500;
    addr[1]     = 32'h500;
    read_req    = 2'b11;
    observe(8, 0);
    check("rr done", tr_done, at(3, 2'b01) | at(7, 2'b10));
    check("rr mr", tr_mr, at(2, 2'b01) | at(6, 2'b10));
    check("rr st", {state[0], state[1]}, 4'b0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
